// File: rtl/riscv_pkg.sv
// Shared RISC-V opcode/funct3 encodings and core-wide defaults.
// Imported by the execute-stage ALU and its branch comparator.
package riscv_pkg;

    localparam int Q_WIDTH_DEF = 4;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_JALR = 3'b000;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/alu_ex_if.sv
// Dispatch and result-broadcast bundle between reservation station and ALU.
// master = reservation station side, slave = ALU side.
interface alu_ex_if #(
    parameter int Q_WIDTH = 4
);
    logic               in_valid;
    logic [9:0]         op_in;
    logic [31:0]        v1_in;
    logic [31:0]        v2_in;
    logic [31:0]        imm_in;
    logic [31:0]        pc_in;
    logic [Q_WIDTH-1:0] rob_tag_in;

    logic               ex_valid;
    logic [Q_WIDTH-1:0] ex_rob_tag;
    logic [31:0]        ex_value;
    logic               ex_taken;
    logic [31:0]        ex_target;

    modport master (
        output in_valid, op_in, v1_in, v2_in,
        output imm_in, pc_in, rob_tag_in,
        input  ex_valid, ex_rob_tag, ex_value,
        input  ex_taken, ex_target
    );

    modport slave (
        input  in_valid, op_in, v1_in, v2_in,
        input  imm_in, pc_in, rob_tag_in,
        output ex_valid, ex_rob_tag, ex_value,
        output ex_taken, ex_target
    );
endinterface

// File: rtl/branch_cmp.sv
// Branch condition evaluator; reserved funct3 codes never take.
module branch_cmp
    import riscv_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        taken
);
    logic eq;
    logic lt;
    logic ltu;

    assign eq  = (a == b);
    assign lt  = ($signed(a) < $signed(b));
    assign ltu = (a < b);

    always_comb begin
        taken = 1'b0;
        case (funct3)
            F3_BEQ:  taken = eq;
            F3_BNE:  taken = ~eq;
            F3_BLT:  taken = lt;
            F3_BGE:  taken = ~lt;
            F3_BLTU: taken = ltu;
            F3_BGEU: taken = ~ltu;
            default: taken = 1'b0;
        endcase
    end
endmodule

// File: rtl/alu_ex.sv
// Single-cycle integer execute stage: computes result, branch/jump outcome
// and next PC, then registers them for broadcast to the RS and ROB.
module alu_ex
    import riscv_pkg::*;
#(
    parameter int Q_WIDTH = Q_WIDTH_DEF
) (
    input  logic  clk_in,
    input  logic  rst_n_in,
    input  logic  rdy_in,
    input  logic  flush_in,
    alu_ex_if.slave bus
);
    logic [2:0]  f3;
    logic [6:0]  opc;
    logic [31:0] v1;
    logic [31:0] op2;
    logic [4:0]  sh;
    logic [31:0] nxt;
    logic        alt;

    logic is_alu;
    logic is_lui;
    logic is_auipc;
    logic is_jal;
    logic is_jalr;
    logic is_br;
    logic br_taken;

    logic [31:0] val;
    logic        tk;
    logic [31:0] tg;

    logic               valid_q;
    logic [Q_WIDTH-1:0] tag_q;
    logic [31:0]        value_q;
    logic               taken_q;
    logic [31:0]        target_q;

    assign f3  = bus.op_in[9:7];
    assign opc = bus.op_in[6:0];
    assign v1  = bus.v1_in;
    assign nxt = bus.pc_in + 32'd4;
    assign alt = bus.imm_in[10];

    assign op2 = (opc == OPC_OP) ? bus.v2_in : bus.imm_in;
    assign sh  = op2[4:0];

    assign is_alu   = (opc == OPC_OP) || (opc == OPC_OP_IMM);
    assign is_lui   = (opc == OPC_LUI);
    assign is_auipc = (opc == OPC_AUIPC);
    assign is_jal   = (opc == OPC_JAL);
    assign is_jalr  = (opc == OPC_JALR) && (f3 == F3_JALR);
    assign is_br    = (opc == OPC_BRANCH);

    branch_cmp u_cmp (
        .funct3 (f3),
        .a      (bus.v1_in),
        .b      (bus.v2_in),
        .taken  (br_taken)
    );

    always_comb begin
        val = '0;
        tk  = 1'b0;
        tg  = nxt;
        unique case (1'b1)
            is_alu: begin
                unique case (f3)
                    F3_ADD: begin
                        // only register-register form has a SUB encoding
                        if ((opc == OPC_OP) && alt) val = v1 - op2;
                        else val = v1 + op2;
                    end
                    F3_SLL:  val = v1 << sh;
                    F3_SLT:  val = {31'd0, $signed(v1) < $signed(op2)};
                    F3_SLTU: val = {31'd0, v1 < op2};
                    F3_XOR:  val = v1 ^ op2;
                    F3_SR: begin
                        if (alt) val = 32'($signed(v1) >>> sh);
                        else val = v1 >> sh;
                    end
                    F3_OR:   val = v1 | op2;
                    F3_AND:  val = v1 & op2;
                endcase
            end
            is_lui:   val = bus.imm_in;
            is_auipc: val = bus.pc_in + bus.imm_in;
            is_jal: begin
                val = nxt;
                tk  = 1'b1;
                tg  = bus.pc_in + bus.imm_in;
            end
            is_jalr: begin
                val = nxt;
                tk  = 1'b1;
                tg  = (v1 + bus.imm_in) & ~32'd1;
            end
            is_br: begin
                tk = br_taken;
                if (br_taken) tg = bus.pc_in + bus.imm_in;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            valid_q  <= 1'b0;
            tag_q    <= '0;
            value_q  <= '0;
            taken_q  <= 1'b0;
            target_q <= '0;
        end else if (rdy_in) begin
            valid_q <= bus.in_valid & ~flush_in;
            if (bus.in_valid) begin
                tag_q    <= bus.rob_tag_in;
                value_q  <= val;
                taken_q  <= tk;
                target_q <= tg;
            end
        end
    end

    assign bus.ex_valid   = valid_q;
    assign bus.ex_rob_tag = tag_q;
    assign bus.ex_value   = value_q;
    assign bus.ex_taken   = taken_q;
    assign bus.ex_target  = target_q;
endmodule

// File: tb/tb_alu_ex.sv
// Self-checking bench for alu_ex: directed vector table, hand sequences
// for flush/stall/reset, and randomized traffic against a reference model.
module tb_alu_ex;
    import riscv_pkg::*;

    localparam int QW = 4;

    typedef struct {
        string       name;
        logic [9:0]  op;
        logic [31:0] v1;
        logic [31:0] v2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [3:0]  tag;
        logic [31:0] e_val;
        logic        e_tk;
        logic [31:0] e_tg;
    } vec_t;

    logic clk;
    logic rst_n;
    logic rdy;
    logic flush;

    int n_chk;
    int n_fail;

    alu_ex_if #(.Q_WIDTH(QW)) bus ();

    alu_ex #(.Q_WIDTH(QW)) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .rdy_in   (rdy),
        .flush_in (flush),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model state
    logic        m_valid;
    logic [3:0]  m_tag;
    logic [31:0] m_val;
    logic        m_tk;
    logic [31:0] m_tg;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic void model(
        input  logic [9:0]  op,
        input  logic [31:0] a,
        input  logic [31:0] b2,
        input  logic [31:0] imm,
        input  logic [31:0] pc,
        output logic [31:0] val,
        output logic        tk,
        output logic [31:0] tg
    );
        int unsigned f3;
        logic [6:0]  opc;
        logic [31:0] b;
        int unsigned s;
        int          sa;
        int          sb;
        longint      q;
        bit          cond;
        f3  = op[9:7];
        opc = op[6:0];
        val = 0;
        tk  = 0;
        tg  = pc + 4;
        if (opc == 7'h33 || opc == 7'h13) begin
            b  = (opc == 7'h33) ? b2 : imm;
            s  = b % 32;
            sa = a;
            sb = b;
            case (f3)
                0: val = (opc == 7'h33 && imm[10]) ? a - b : a + b;
                1: val = a * (32'd1 << s);
                2: val = (sa < sb) ? 1 : 0;
                3: val = (a < b) ? 1 : 0;
                4: val = a ^ b;
                5: begin
                    if (imm[10]) begin
                        q = sa;
                        q = q / (64'sd1 << s);
                        if (sa < 0 && (a % (32'd1 << s)) != 0) q = q - 1;
                        val = q[31:0];
                    end else begin
                        val = a / (32'd1 << s);
                    end
                end
                6: val = a | b;
                default: val = a & b;
            endcase
        end else if (opc == 7'h37) begin
            val = imm;
        end else if (opc == 7'h17) begin
            val = pc + imm;
        end else if (opc == 7'h6F) begin
            val = pc + 4;
            tk  = 1;
            tg  = pc + imm;
        end else if (opc == 7'h67 && f3 == 0) begin
            val = pc + 4;
            tk  = 1;
            tg  = {a[31:1] + imm[31:1] + 31'(a[0] & imm[0]), 1'b0};
        end else if (opc == 7'h63) begin
            sa   = a;
            sb   = b2;
            cond = 0;
            case (f3)
                0: cond = (a == b2);
                1: cond = (a != b2);
                4: cond = (sa < sb);
                5: cond = (sa >= sb);
                6: cond = (a < b2);
                7: cond = (a >= b2);
                default: cond = 0;
            endcase
            tk = cond;
            if (cond) tg = pc + imm;
        end
    endfunction

    task automatic drive(input logic v, input logic [9:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic [31:0] pc,
                         input logic [3:0] tag);
        bus.in_valid   = v;
        bus.op_in      = op;
        bus.v1_in      = a;
        bus.v2_in      = b;
        bus.imm_in     = imm;
        bus.pc_in      = pc;
        bus.rob_tag_in = tag;
    endtask

    task automatic chk_out(input string nm, input logic v,
                           input logic [3:0] tag, input logic [31:0] val,
                           input logic tk, input logic [31:0] tg);
        chk({nm, ".valid"}, 32'(bus.ex_valid), 32'(v));
        chk({nm, ".tag"}, 32'(bus.ex_rob_tag), 32'(tag));
        chk({nm, ".value"}, bus.ex_value, val);
        chk({nm, ".taken"}, 32'(bus.ex_taken), 32'(tk));
        chk({nm, ".target"}, bus.ex_target, tg);
    endtask

    vec_t vt[$];

    function automatic logic [9:0] mk(input logic [2:0] f3,
                                       input logic [6:0] o);
        return {f3, o};
    endfunction

    logic [3:0]  hold_tag;
    logic [31:0] hold_val;
    logic        hold_tk;
    logic [31:0] hold_tg;

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        rdy    = 1'b1;
        flush  = 1'b0;
        drive(0, '0, '0, '0, '0, '0, '0);

        vt.push_back('{"add", mk(0, 7'h33), 5, 7, 0, 32'h0, 3,
                       12, 0, 32'h4});
        vt.push_back('{"sub", mk(0, 7'h33), 5, 7, 32'h400, 32'h10, 4,
                       32'hFFFFFFFE, 0, 32'h14});
        vt.push_back('{"sra", mk(5, 7'h33), 32'h80000000, 4, 32'h400,
                       32'h20, 5, 32'hF8000000, 0, 32'h24});
        vt.push_back('{"srl", mk(5, 7'h33), 32'h80000000, 4, 32'h0,
                       32'h20, 6, 32'h08000000, 0, 32'h24});
        vt.push_back('{"blt", mk(4, 7'h63), 32'hFFFFFFFF, 1, 32'h20,
                       32'h100, 7, 0, 1, 32'h120});
        vt.push_back('{"bltu", mk(6, 7'h63), 32'hFFFFFFFF, 1, 32'h20,
                       32'h100, 8, 0, 0, 32'h104});
        vt.push_back('{"jalr", mk(0, 7'h67), 32'h1003, 0, 0,
                       32'h40, 9, 32'h44, 1, 32'h1002});
        vt.push_back('{"lui", mk(0, 7'h37), 0, 0, 32'h12345000,
                       32'h200, 10, 32'h12345000, 0, 32'h204});
        vt.push_back('{"auipc", mk(0, 7'h17), 0, 0, 32'h1000,
                       32'h200, 11, 32'h1200, 0, 32'h204});
        vt.push_back('{"jal", mk(0, 7'h6F), 0, 0, 32'hFFFFFFF0,
                       32'h300, 12, 32'h304, 1, 32'h2F0});
        vt.push_back('{"addi_b10", mk(0, 7'h13), 1, 32'h55, 32'h400,
                       32'h0, 13, 32'h401, 0, 32'h4});
        vt.push_back('{"slt", mk(2, 7'h33), 32'hFFFFFFFF, 1, 0,
                       32'h0, 14, 1, 0, 32'h4});
        vt.push_back('{"sltu", mk(3, 7'h33), 32'hFFFFFFFF, 1, 0,
                       32'h0, 15, 0, 0, 32'h4});
        vt.push_back('{"add_wrap", mk(0, 7'h33), 32'hFFFFFFFF, 1, 0,
                       32'hFFFFFFFC, 1, 0, 0, 32'h0});
        vt.push_back('{"bad_opc", mk(0, 7'h7F), 3, 3, 8,
                       32'h500, 2, 0, 0, 32'h504});
        vt.push_back('{"bad_br", mk(2, 7'h63), 3, 3, 8,
                       32'h600, 3, 0, 0, 32'h604});
        vt.push_back('{"slli", mk(1, 7'h13), 32'h3, 0, 32'h21,
                       32'h700, 4, 32'h6, 0, 32'h704});

        // reset state
        #2;
        chk_out("reset", 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        chk_out("reset_hold", 0, 0, 0, 0, 0);
        rst_n = 1'b1;

        foreach (vt[i]) begin
            drive(1, vt[i].op, vt[i].v1, vt[i].v2, vt[i].imm,
                  vt[i].pc, vt[i].tag);
            @(posedge clk);
            #1;
            chk_out(vt[i].name, 1, vt[i].tag, vt[i].e_val,
                    vt[i].e_tk, vt[i].e_tg);
        end

        // idle cycle: valid drops, data held
        drive(0, mk(0, 7'h33), 1, 1, 0, 32'h900, 9);
        @(posedge clk);
        #1;
        chk_out("idle_hold", 0, 4, 32'h6, 0, 32'h704);

        // flush beats in_valid
        drive(1, mk(0, 7'h33), 5, 7, 0, 32'h0, 3);
        @(posedge clk);
        #1;
        chk_out("pre_flush", 1, 3, 12, 0, 32'h4);
        drive(1, mk(0, 7'h6F), 0, 0, 32'h40, 32'h80, 6);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush.valid", 32'(bus.ex_valid), 0);

        // stall: three cycles with rdy low, inputs churning
        drive(1, mk(0, 7'h33), 5, 7, 0, 32'h0, 3);
        @(posedge clk);
        #1;
        chk_out("pre_stall", 1, 3, 12, 0, 32'h4);
        rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(k != 1, mk(0, 7'h6F), 32'(k), 0, 32'h80,
                  32'h1000, 4'(k + 5));
            flush = (k == 2);
            @(posedge clk);
            #1;
            chk_out($sformatf("stall%0d", k), 1, 3, 12, 0, 32'h4);
        end
        rdy   = 1'b1;
        flush = 1'b0;

        // async reset mid-cycle while a result is valid
        drive(1, mk(0, 7'h67), 32'h1003, 0, 0, 32'h40, 9);
        @(posedge clk);
        #1;
        chk_out("pre_rst", 1, 9, 32'h44, 1, 32'h1002);
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("mid_rst", 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, mk(0, 7'h33), 5, 7, 0, 32'h0, 3);
        @(posedge clk);
        #1;
        chk_out("post_rst", 1, 3, 12, 0, 32'h4);

        // randomized traffic against the reference model
        m_valid = 1;
        m_tag   = 3;
        m_val   = 12;
        m_tk    = 0;
        m_tg    = 32'h4;
        for (int n = 0; n < 400; n++) begin
            logic [6:0]  opc;
            logic [9:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            logic [31:0] imm;
            logic [31:0] pc;
            logic [3:0]  tag;
            logic        v;
            logic [31:0] r_val;
            logic        r_tk;
            logic [31:0] r_tg;
            case ($urandom_range(0, 8))
                0, 1: opc = 7'h33;
                2, 3: opc = 7'h13;
                4: opc = 7'h37;
                5: opc = 7'h17;
                6: opc = 7'h6F;
                7: opc = 7'h67;
                default: opc = ($urandom_range(0, 5) == 0) ?
                               7'($urandom) : 7'h63;
            endcase
            op  = {3'($urandom), opc};
            a   = $urandom;
            b   = ($urandom_range(0, 3) == 0) ? a : $urandom;
            imm = $urandom;
            pc  = {$urandom_range(0, 32'h3FFFFFFF), 2'b00};
            tag = 4'($urandom);
            v   = ($urandom_range(0, 4) != 0);
            drive(v, op, a, b, imm, pc, tag);
            rdy   = ($urandom_range(0, 9) != 0);
            flush = ($urandom_range(0, 9) == 0);
            model(op, a, b, imm, pc, r_val, r_tk, r_tg);
            if (rdy) begin
                m_valid = v & ~flush;
                if (v) begin
                    m_tag = tag;
                    m_val = r_val;
                    m_tk  = r_tk;
                    m_tg  = r_tg;
                end
            end
            @(posedge clk);
            #1;
            chk_out($sformatf("rnd%0d", n), m_valid, m_tag, m_val,
                    m_tk, m_tg);
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule

// File: doc/alu_ex.md
ALU_EX -- requirements
Module: alu_ex

Interface
REQ-001 Parameter: Q_WIDTH, default 4, ROB tag width; tag 0 means "no tag".
REQ-002 Port: clk_in  input  1  system clock; all state changes on its rising edge.
REQ-003 Port: rst_n_in  input  1  reset, asynchronous assert, active-low.
REQ-004 Port: rdy_in  input  1  global ready; low freezes all state.
REQ-005 Port: flush_in  input  1  misprediction clear from ROB.
REQ-006 Port: in_valid  input  1  RS dispatch valid (RS has_ex_node).
REQ-007 Port: op_in  input  10  {funct3[9:7], opcode[6:0]}.
REQ-008 Port: v1_in, v2_in  input  32 each  rs1/rs2 operand values.
REQ-009 Port: imm_in  input  32  sign-extended immediate; imm_in[10] = instr[30] for OP and shift-immediate.
REQ-010 Port: pc_in  input  32  instruction address.
REQ-011 Port: rob_tag_in  input  Q_WIDTH  destination ROB tag.
REQ-012 Port: ex_valid  output  1  result broadcast valid (RS update_control).
REQ-013 Port: ex_rob_tag  output  Q_WIDTH  result tag (RS target_ROB_pos).
REQ-014 Port: ex_value  output  32  writeback value (RS V_ex).
REQ-015 Port: ex_taken  output  1  control transfer taken.
REQ-016 Port: ex_target  output  32  next PC of this instruction.

Function
REQ-017 Exactly one registered stage: inputs accepted at edge N SHALL appear on outputs after edge N, held until next edge.
REQ-018 At each enabled edge, ex_valid SHALL load in_valid & ~flush_in; data registers load only when in_valid, else hold.
REQ-019 flush_in SHALL beat simultaneous in_valid: ex_valid 0 next cycle.
REQ-020 rdy_in low SHALL hold all registers, flush included.
REQ-021 OP/OP-IMM (0110011/0010011): ADD/SUB (SUB only OP with imm_in[10]), SLL, SLT, SLTU, XOR, SRL/SRA (imm_in[10]), OR, AND; OP-IMM uses imm_in as operand 2; shift amount = operand2[4:0].
REQ-022 LUI: value = imm_in; AUIPC: value = pc_in + imm_in.
REQ-023 JAL: value = pc_in+4, taken=1, target = pc_in+imm_in.
REQ-024 JALR: value = pc_in+4, taken=1, target = (v1_in+imm_in) & ~1.
REQ-025 BRANCH (1100011): funct3 BEQ/BNE/BLT/BGE/BLTU/BGEU; taken per compare; target = taken ? pc_in+imm_in : pc_in+4; value = 0.
REQ-026 Non-control ops: taken=0, target=pc_in+4.
REQ-027 Unlisted opcode/funct3: value 0, taken 0, target pc_in+4, ex_valid still asserted (ROB retires it).
REQ-028 All arithmetic modulo 2^32; signed compares two's complement; no overflow flagging.

Reset
REQ-029 rst_n_in low SHALL immediately force ex_valid=0, ex_rob_tag=0, ex_value=0, ex_taken=0, ex_target=0, irrespective of clock and rdy_in.
REQ-030 First capture SHALL occur on the first enabled edge after rst_n_in deasserts; reset mid-operation drops the in-flight result.

Structure
REQ-031 Opcode values, funct3 codes and Q_WIDTH default SHALL be in the shared package riscv_pkg.
REQ-032 One sub-module branch_cmp (combinational: funct3, a, b -> taken) SHALL be instantiated; everything else inline.

Verification
REQ-033 ADD: v1=5, v2=7, op OP/000, imm[10]=0, tag=3 -> next cycle ex_valid=1, tag=3, value=12, taken=0, target=pc+4.
REQ-034 SRA: v1=0x80000000, v2=4, imm[10]=1 -> value=0xF8000000; SRL same -> 0x08000000.
REQ-035 BLT: v1=-1, v2=1, pc=0x100, imm=0x20 -> taken=1, target=0x120; BLTU same operands -> taken=0, target=0x104.
REQ-036 JALR: v1=0x1003, imm=0, pc=0x40 -> value=0x44, target=0x1002, taken=1.
REQ-037 in_valid=1 with flush_in=1 same edge -> ex_valid=0 next cycle; rdy_in=0 for 3 cycles -> outputs unchanged.
REQ-038 rst_n_in pulsed low mid-cycle while ex_valid=1 -> all outputs 0 before next edge.
